// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl -- refresh scheduler for a 4-digit seven-segment driver.
//
// Scans the four digit slots one after another. Each slot starts with a
// dead-time blank so the previous digit cannot ghost into this one. The lit
// window after the blank is PWM-dimmed. Digit values are double-buffered:
// a load lands in a pending register and only moves into the displayed
// shadow register on a frame boundary.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to suppress leading zero
// digits (slots 3..1). Slot 0 is always lit.
//
// Ports:
//   clk          in   system clock, rising edge
//   rst          in   synchronous reset, active low
//   enable       in   scan enable; dropping it returns to IDLE next cycle
//   brightness   in   [3:0] PWM duty, 0 = dark, 15 = full
//   load         in   request to take digits_in
//   digits_in    in   [15:0] {digit3,digit2,digit1,digit0}
//   load_pending out  an accepted update is waiting for a frame boundary
//   load_ack     out  one-cycle pulse when the pending update commits
//   digit_out    out  [3:0] shadow digit for the current slot
//   anode_sel    out  [1:0] current slot index
//   display_on   out  segment enable to the driver
//   frame_tick   out  one-cycle pulse in the last cycle of slot 3
module display_scan_ctrl #(
  parameter int CLK_DIV      = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [3:0]  brightness,
  input  logic        load,
  input  logic [15:0] digits_in,
  output logic        load_pending,
  output logic        load_ack,
  output logic [3:0]  digit_out,
  output logic [1:0]  anode_sel,
  output logic        display_on,
  output logic        frame_tick
);

  localparam int SW = $clog2(CLK_DIV);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(CLK_DIV - 1);
  localparam logic [SW-1:0] BLANK_LAST = SW'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;

  state_t        r_state;
  logic [SW-1:0] r_slot_cnt;
  logic [1:0]    r_anode_sel;
  logic [3:0]    r_pwm_cnt;
  logic [15:0]   r_shadow;
  logic [15:0]   r_pending;
  logic          r_load_pending;
  logic          r_load_ack;
  logic [3:0]    r_digit_out;

  state_t        w_state_nxt;
  logic [SW-1:0] w_slot_nxt;
  logic [1:0]    w_anode_nxt;
  logic [3:0]    w_pwm_nxt;
  logic [15:0]   w_shadow_nxt;
  logic [3:0]    w_digit_nxt;
  logic          w_frame_tick;
  logic          w_commit;
  logic          w_accept;
  logic          w_lz_blank;

  // Next-state and counter logic.
  always_comb begin
    w_state_nxt = r_state;
    w_slot_nxt  = r_slot_cnt;
    w_anode_nxt = r_anode_sel;
    w_pwm_nxt   = r_pwm_cnt;
    case (r_state)
      IDLE: begin
        if (enable) begin
          w_state_nxt = BLANK;
          w_slot_nxt  = '0;
          w_anode_nxt = 2'd0;
        end
      end
      BLANK, ON: begin
        if (!enable) begin
          w_state_nxt = IDLE;
          w_slot_nxt  = '0;
          w_anode_nxt = 2'd0;
          w_pwm_nxt   = 4'd0;
        end else if (r_slot_cnt == SLOT_LAST) begin
          w_state_nxt = BLANK;
          w_slot_nxt  = '0;
          w_anode_nxt = r_anode_sel + 2'd1;
          w_pwm_nxt   = 4'd0;
        end else begin
          w_slot_nxt = r_slot_cnt + SW'(1);
          if (r_state == BLANK) begin
            if (r_slot_cnt == BLANK_LAST) begin
              w_state_nxt = ON;
              w_pwm_nxt   = 4'd0;
            end
          end else begin
            // 15-step PWM period so brightness 15 is fully on
            w_pwm_nxt = (r_pwm_cnt == 4'd14) ? 4'd0 : r_pwm_cnt + 4'd1;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_slot_nxt  = '0;
        w_anode_nxt = 2'd0;
        w_pwm_nxt   = 4'd0;
      end
    endcase
  end

  assign w_frame_tick = (r_state != IDLE) && (r_anode_sel == 2'd3) &&
                        (r_slot_cnt == SLOT_LAST);
  // Commit at the edge that ends the frame (or the first IDLE cycle), so the
  // new shadow and slot 0 appear together in the next cycle.
  assign w_commit     = r_load_pending && (w_frame_tick || r_state == IDLE);
  assign w_accept     = load && !r_load_pending;
  assign w_shadow_nxt = w_commit ? r_pending : r_shadow;

  // Digit is selected from the next shadow with the next slot index so
  // digit_out and anode_sel always switch on the same edge.
  always_comb begin
    w_digit_nxt = w_shadow_nxt[3:0];
    case (w_anode_nxt)
      2'd0: w_digit_nxt = w_shadow_nxt[3:0];
      2'd1: w_digit_nxt = w_shadow_nxt[7:4];
      2'd2: w_digit_nxt = w_shadow_nxt[11:8];
      2'd3: w_digit_nxt = w_shadow_nxt[15:12];
      default: w_digit_nxt = w_shadow_nxt[3:0];
    endcase
  end

`ifdef LEADING_ZERO_BLANK_EN
  // Slot k is dark when digits k..3 are all zero; slot 0 never blanks.
  always_comb begin
    w_lz_blank = 1'b0;
    case (r_anode_sel)
      2'd1: w_lz_blank = (r_shadow[15:4]  == 12'd0);
      2'd2: w_lz_blank = (r_shadow[15:8]  == 8'd0);
      2'd3: w_lz_blank = (r_shadow[15:12] == 4'd0);
      default: w_lz_blank = 1'b0;
    endcase
  end
`else
  assign w_lz_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state        <= IDLE;
      r_slot_cnt     <= '0;
      r_anode_sel    <= 2'd0;
      r_pwm_cnt      <= 4'd0;
      r_shadow       <= 16'd0;
      r_pending      <= 16'd0;
      r_load_pending <= 1'b0;
      r_load_ack     <= 1'b0;
      r_digit_out    <= 4'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_slot_cnt  <= w_slot_nxt;
      r_anode_sel <= w_anode_nxt;
      r_pwm_cnt   <= w_pwm_nxt;
      r_shadow    <= w_shadow_nxt;
      r_digit_out <= w_digit_nxt;
      r_load_ack  <= w_commit;
      if (w_accept) begin
        r_pending      <= digits_in;
        r_load_pending <= 1'b1;
      end else if (w_commit) begin
        r_load_pending <= 1'b0;
      end
    end
  end

  assign load_pending = r_load_pending;
  assign load_ack     = r_load_ack;
  assign digit_out    = r_digit_out;
  assign anode_sel    = r_anode_sel;
  assign frame_tick   = w_frame_tick;
  // brightness is applied combinationally so a change takes effect at once
  assign display_on   = (r_state == ON) && (r_pwm_cnt < brightness) && !w_lz_blank;

endmodule

// File: tb/tb_display_scan_ctrl.sv
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [3:0]  brightness;
  logic        load;
  logic [15:0] digits_in;
  logic        load_pending;
  logic        load_ack;
  logic [3:0]  digit_out;
  logic [1:0]  anode_sel;
  logic        display_on;
  logic        frame_tick;

  int tests = 0;
  int errs  = 0;
  int cyc   = 0;

`ifdef LEADING_ZERO_BLANK_EN
  localparam logic LZ_ON = 1'b0;
`else
  localparam logic LZ_ON = 1'b1;
`endif

  display_scan_ctrl #(.CLK_DIV(32), .BLANK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .brightness(brightness),
    .load(load), .digits_in(digits_in), .load_pending(load_pending),
    .load_ack(load_ack), .digit_out(digit_out), .anode_sel(anode_sel),
    .display_on(display_on), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, ".display_on"},   32'(display_on),   0);
    chk({tag, ".anode_sel"},    32'(anode_sel),    0);
    chk({tag, ".digit_out"},    32'(digit_out),    0);
    chk({tag, ".load_pending"}, 32'(load_pending), 0);
    chk({tag, ".load_ack"},     32'(load_ack),     0);
    chk({tag, ".frame_tick"},   32'(frame_tick),   0);
  endtask

  initial begin
    rst = 1'b0; enable = 1'b0; brightness = 4'd0; load = 1'b0; digits_in = 16'd0;

    // Reset state
    step(2);
    chk_zero_outs("reset");
    rst = 1'b1;
    step();
    chk("idle.anode", 32'(anode_sel), 0);
    chk("idle.on",    32'(display_on), 0);

    // 1: full-brightness scan, slot timing and frame_tick
    enable = 1'b1; brightness = 4'd15;
    step();
    cyc = 0;
    for (int k = 0; k < 160; k++) begin
      chk("scan.anode", 32'(anode_sel), 32'((k / 32) % 4));
      chk("scan.on",    32'(display_on), 32'((k % 32) >= 4));
      chk("scan.tick",  32'(frame_tick), 32'((k % 32) == 31 && ((k / 32) % 4) == 3));
      step();
    end

    // 2: PWM duty 5/15, then dark
    brightness = 4'd5;
    step(4);
    for (int k = 0; k < 28; k++) begin
      chk("pwm5.on", 32'(display_on), 32'((k % 15) < 5));
      step();
    end
    brightness = 4'd0;
    for (int k = 0; k < 32; k++) begin
      chk("pwm0.on", 32'(display_on), 0);
      step();
    end

    // 3: load handshake, commit at frame boundary
    brightness = 4'd15;
    step(298 - cyc);
    load = 1'b1; digits_in = 16'h1234;
    chk("ld.pend_before", 32'(load_pending), 0);
    step();
    chk("ld.pend", 32'(load_pending), 1);
    digits_in = 16'hFFFF;
    step();
    load = 1'b0;
    chk("ld.pend_hold", 32'(load_pending), 1);
    step(383 - cyc);
    chk("ld.tick",      32'(frame_tick), 1);
    chk("ld.ack_early", 32'(load_ack),   0);
    chk("ld.old_digit", 32'(digit_out),  0);
    step();
    chk("ld.ack",     32'(load_ack),     1);
    chk("ld.pend_clr",32'(load_pending), 0);
    chk("ld.anode0",  32'(anode_sel),    0);
    chk("ld.digit0",  32'(digit_out),    4);
    step();
    chk("ld.ack_pulse", 32'(load_ack), 0);
    step(31);
    chk("ld.anode1", 32'(anode_sel), 1);
    chk("ld.digit1", 32'(digit_out), 3);
    step(32);
    chk("ld.digit2", 32'(digit_out), 2);

    // 4: drop enable mid-ON in slot 2 with a load; commit in IDLE
    step(10);
    chk("dis.on_before", 32'(display_on), 1);
    enable = 1'b0; load = 1'b1; digits_in = 16'hABCD;
    step();
    load = 1'b0;
    chk("dis.on",    32'(display_on),   0);
    chk("dis.anode", 32'(anode_sel),    0);
    chk("dis.pend",  32'(load_pending), 1);
    chk("dis.ack0",  32'(load_ack),     0);
    chk("dis.digit", 32'(digit_out),    4);
    step();
    chk("dis.ack",      32'(load_ack),     1);
    chk("dis.pend_clr", 32'(load_pending), 0);
    chk("dis.newdigit", 32'(digit_out),    32'hD);
    step();
    chk("dis.ack_pulse", 32'(load_ack), 0);
    enable = 1'b1;
    step();
    chk("reen.anode", 32'(anode_sel),  0);
    chk("reen.blank", 32'(display_on), 0);
    step(4);
    chk("reen.on", 32'(display_on), 1);
    step(96);
    chk("reen.anode3", 32'(anode_sel), 3);
    chk("reen.digit3", 32'(digit_out), 32'hA);

    // 5: reset during ON with a pending update
    load = 1'b1; digits_in = 16'h5555;
    step();
    load = 1'b0;
    chk("rst.pend_before", 32'(load_pending), 1);
    rst = 1'b0; enable = 1'b0;
    step();
    chk_zero_outs("rst_mid");
    rst = 1'b1;
    step();
    chk("rst.no_ack", 32'(load_ack),     0);
    chk("rst.pend",   32'(load_pending), 0);
    enable = 1'b1;
    step();
    step(32);
    chk("rst.anode1",       32'(anode_sel), 1);
    chk("rst.shadow_clear", 32'(digit_out), 0);

    // 6: leading-zero handling (dark slots only with the feature built in)
    enable = 1'b0; load = 1'b1; digits_in = 16'h0040;
    step();
    load = 1'b0;
    step();
    chk("lz.ack", 32'(load_ack), 1);
    enable = 1'b1;
    step();
    step(10);
    chk("lz40.s0", 32'(display_on), 1);
    chk("lz40.d0", 32'(digit_out),  0);
    step(32);
    chk("lz40.s1", 32'(display_on), 1);
    chk("lz40.d1", 32'(digit_out),  4);
    step(32);
    chk("lz40.s2", 32'(display_on), 32'(LZ_ON));
    step(32);
    chk("lz40.s3", 32'(display_on), 32'(LZ_ON));
    enable = 1'b0; load = 1'b1; digits_in = 16'h0000;
    step();
    load = 1'b0;
    step();
    chk("lz0.ack", 32'(load_ack), 1);
    enable = 1'b1;
    step();
    step(10);
    chk("lz0.s0", 32'(display_on), 1);
    step(32);
    chk("lz0.s1", 32'(display_on), 32'(LZ_ON));
    step(32);
    chk("lz0.s2", 32'(display_on), 32'(LZ_ON));
    step(32);
    chk("lz0.s3", 32'(display_on), 32'(LZ_ON));

    $display("[TB] %0d tests run, %0d failed", tests, errs);
    $finish;
  end

endmodule
